shift_receiver: RTL

SHIFT_RECEIVER -- requirements
Module: shift_receiver

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_receiver.sv | 109 ++++++++++
 2 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types for the serial shift blocks. It holds the
//                collector FSM state encoding and the shift-direction
//                constants used by shift_receiver and shift_register.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    // Collector state. IDLE means no bits of the current word are held.
    // SHIFT means 1..BUS_WIDTH-1 bits are held.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift direction as seen on i_sht_lr.
    localparam logic SHT_LEFT  = 1'b0;  // MSB first
    localparam logic SHT_RIGHT = 1'b1;  // LSB first

endpackage
`default_nettype wire

// File: rtl/shift_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : shift_receiver
//  Description : Serial-to-parallel receiver. It collects BUS_WIDTH bits
//                from i_shift on each cycle where i_valid is high. The
//                direction is latched from the first bit of each word.
//                Completed words go into a one-word output buffer. A
//                completed word that finds the buffer full and not being
//                consumed is dropped, and this sets a sticky overrun flag.
//  Ports       : clk, rst_n (async, active-low)
//                i_shift, i_valid, i_sht_lr, i_clr   serial side
//                i_data_ready                        consumer handshake
//                o_data, o_data_valid                parallel word out
//                o_busy, o_overrun                   status
//  Revision    : 1.0  initial release
// ============================================================================
module shift_receiver
    import shift_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_shift,
    input  logic                 i_valid,
    input  logic                 i_sht_lr,
    input  logic                 i_clr,
    input  logic                 i_data_ready,
    output logic [BUS_WIDTH-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int CNT_W = $clog2(BUS_WIDTH) + 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BUS_WIDTH-1:0] r_sr;
    logic                 r_dir;

    logic                 w_dir;
    logic                 w_last;
    logic                 w_done;
    logic [BUS_WIDTH-1:0] w_sr_next;

    // The first bit of a word uses the live i_sht_lr. Later bits use the
    // direction latched when that first bit was taken.
    always_comb begin
        w_dir     = (r_state == IDLE) ? i_sht_lr : r_dir;
        w_last    = (r_cnt == CNT_W'(BUS_WIDTH - 1));
        w_done    = i_valid && w_last;
        w_sr_next = (w_dir == SHT_RIGHT) ? {i_shift, r_sr[BUS_WIDTH-1:1]}
                                         : {r_sr[BUS_WIDTH-2:0], i_shift};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_dir        <= SHT_LEFT;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (i_clr) begin
            // Abort wins over any bit presented in the same cycle.
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (i_valid) begin
                r_sr <= w_sr_next;
                if (r_state == IDLE) begin
                    r_dir <= i_sht_lr;
                end
                if (w_last) begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= SHIFT;
                    o_busy  <= 1'b1;
                end
            end

            // One-word output buffer. A new word may load when the buffer
            // is empty or is being drained on this same edge. Otherwise the
            // new word is dropped and the current word is kept.
            if (w_done) begin
                if (!o_data_valid || i_data_ready) begin
                    o_data       <= w_sr_next;
                    o_data_valid <= 1'b1;
                end else begin
                    o_overrun    <= 1'b1;
                end
            end else if (o_data_valid && i_data_ready) begin
                o_data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
